// File: rtl/i2c_slave_responder.sv
// I2C target answering byte writes and random/current-address reads against a local register file.
// SCL/SDA are oversampled on clk; SDA is only ever pulled low or released.
`timescale 1ns/1ps
module i2c_slave_responder #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h50,
  parameter int         ADDR_W      = 8,
  parameter int         SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_scl,
  inout  wire               io_sda,
  input  logic              i_local_we,
  input  logic [ADDR_W-1:0] i_local_addr,
  input  logic [7:0]        i_local_data,
  output logic              o_sda_mode,
  output logic [1:0]        o_slave_state,
  output logic              o_rx_valid,
  output logic [ADDR_W-1:0] o_rx_addr,
  output logic [7:0]        o_rx_data,
  output logic              o_busy
);

  localparam int DEPTH = 1 << ADDR_W;

  // Encoding doubles as the registered outputs: bit 5 is o_sda_mode, bits 4:3 are o_slave_state.
  typedef enum logic [5:0] {
    ST_IDLE      = 6'b0_00_000,
    ST_DEV_ADDR  = 6'b0_00_001,
    ST_PTR_ADDR  = 6'b0_00_010,
    ST_WR_DATA   = 6'b0_00_011,
    ST_RX_ACK    = 6'b0_00_100,
    ST_ACK_DEV   = 6'b1_01_000,
    ST_ACK_PTR   = 6'b1_01_001,
    ST_ACK_WR    = 6'b1_01_010,
    ST_TX_DATA   = 6'b1_10_000,
    ST_WAIT_STOP = 6'b0_11_000
  } state_e;

  state_e                 state_q;
  logic [SYNC_STAGES-1:0] sclSync_q, sdaSync_q;
  logic                   sclPrev_q, sdaPrev_q;
  logic [3:0]             bitCnt_q;
  logic [7:0]             rxShift_q;
  logic [6:0]             txShift_q;
  logic [ADDR_W-1:0]      ptr_q;
  logic                   sdaOe_q;
  logic                   nack_q;
  logic                   busy_q;
  logic                   rxValid_q;
  logic [ADDR_W-1:0]      rxAddr_q;
  logic [7:0]             rxData_q;
  logic [7:0]             mem_q [DEPTH];

  logic              sclNow, sdaNow, sclRise, sclFall, startDet, stopDet;
  logic              shiftIn, wrCommit;
  logic [ADDR_W-1:0] ptrInc;
  logic [7:0]        memAtPtr, memAtInc;

  assign sclNow   = sclSync_q[SYNC_STAGES-1];
  assign sdaNow   = sdaSync_q[SYNC_STAGES-1];
  assign sclRise  = sclNow & ~sclPrev_q;
  assign sclFall  = ~sclNow & sclPrev_q;
  assign startDet = sclNow & sclPrev_q & sdaPrev_q & ~sdaNow;
  assign stopDet  = sclNow & sclPrev_q & ~sdaPrev_q & sdaNow;

  assign shiftIn  = (state_q == ST_DEV_ADDR) || (state_q == ST_PTR_ADDR) || (state_q == ST_WR_DATA);
  assign wrCommit = (state_q == ST_WR_DATA) && sclFall && (bitCnt_q == 4'd8);
  assign ptrInc   = ptr_q + ADDR_W'(1);
  assign memAtPtr = mem_q[ptr_q];
  assign memAtInc = mem_q[ptrInc];

  assign io_sda        = sdaOe_q ? 1'b0 : 1'bz;
  assign o_sda_mode    = state_q[5];
  assign o_slave_state = state_q[4:3];
  assign o_rx_valid    = rxValid_q;
  assign o_rx_addr     = rxAddr_q;
  assign o_rx_data     = rxData_q;
  assign o_busy        = busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclSync_q <= '1;
      sdaSync_q <= '1;
      sclPrev_q <= 1'b1;
      sdaPrev_q <= 1'b1;
      state_q   <= ST_IDLE;
      bitCnt_q  <= '0;
      rxShift_q <= '0;
      txShift_q <= '0;
      ptr_q     <= '0;
      sdaOe_q   <= 1'b0;
      nack_q    <= 1'b0;
      busy_q    <= 1'b0;
      rxValid_q <= 1'b0;
      rxAddr_q  <= '0;
      rxData_q  <= '0;
    end else begin
      sclSync_q <= {sclSync_q[SYNC_STAGES-2:0], i_scl};
      sdaSync_q <= {sdaSync_q[SYNC_STAGES-2:0], io_sda};
      sclPrev_q <= sclNow;
      sdaPrev_q <= sdaNow;
      rxValid_q <= 1'b0;

      if (startDet) begin
        state_q  <= ST_DEV_ADDR;
        bitCnt_q <= '0;
        sdaOe_q  <= 1'b0;
        busy_q   <= 1'b1;
      end else if (stopDet) begin
        state_q <= ST_IDLE;
        sdaOe_q <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        if (sclRise && shiftIn) begin
          rxShift_q <= {rxShift_q[6:0], sdaNow};
          bitCnt_q  <= bitCnt_q + 4'd1;
        end
        // Every driven-SDA change happens on the cycle after a synced SCL fall.
        case (state_q)
          ST_DEV_ADDR: begin
            if (sclFall && bitCnt_q == 4'd8) begin
              if (rxShift_q[7:1] == SLAVE_ADDR) begin
                state_q <= ST_ACK_DEV;
                sdaOe_q <= 1'b1;
              end else begin
                state_q <= ST_WAIT_STOP;
              end
            end
          end
          ST_ACK_DEV: begin
            if (sclFall) begin
              bitCnt_q <= '0;
              if (rxShift_q[0]) begin
                state_q   <= ST_TX_DATA;
                txShift_q <= memAtPtr[6:0];
                sdaOe_q   <= ~memAtPtr[7];
              end else begin
                state_q <= ST_PTR_ADDR;
                sdaOe_q <= 1'b0;
              end
            end
          end
          ST_PTR_ADDR: begin
            if (sclFall && bitCnt_q == 4'd8) begin
              ptr_q   <= rxShift_q[ADDR_W-1:0];
              state_q <= ST_ACK_PTR;
              sdaOe_q <= 1'b1;
            end
          end
          ST_ACK_PTR, ST_ACK_WR: begin
            if (sclFall) begin
              state_q  <= ST_WR_DATA;
              bitCnt_q <= '0;
              sdaOe_q  <= 1'b0;
            end
          end
          ST_WR_DATA: begin
            if (wrCommit) begin
              state_q   <= ST_ACK_WR;
              sdaOe_q   <= 1'b1;
              rxValid_q <= 1'b1;
              rxAddr_q  <= ptr_q;
              rxData_q  <= rxShift_q;
              ptr_q     <= ptrInc;
            end
          end
          ST_TX_DATA: begin
            if (sclFall) begin
              if (bitCnt_q == 4'd7) begin
                state_q  <= ST_RX_ACK;
                sdaOe_q  <= 1'b0;
                bitCnt_q <= '0;
              end else begin
                sdaOe_q   <= ~txShift_q[6];
                txShift_q <= {txShift_q[5:0], 1'b0};
                bitCnt_q  <= bitCnt_q + 4'd1;
              end
            end
          end
          ST_RX_ACK: begin
            if (sclRise) begin
              nack_q <= sdaNow;
            end else if (sclFall) begin
              if (nack_q) begin
                state_q <= ST_WAIT_STOP;
              end else begin
                ptr_q     <= ptrInc;
                txShift_q <= memAtInc[6:0];
                sdaOe_q   <= ~memAtInc[7];
                bitCnt_q  <= '0;
                state_q   <= ST_TX_DATA;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  // A master-written byte takes priority over a local write landing in the same cycle.
  always_ff @(posedge clk) begin
    if (wrCommit) begin
      mem_q[ptr_q] <= rxShift_q;
    end else if (i_local_we) begin
      mem_q[i_local_addr] <= i_local_data;
    end
  end

endmodule
